// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle logic/arith/compare/shift ops plus
// iterative unsigned multiply (shift-add) and divide (restoring) with a HI result.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             dz
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_XNOR  = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_SLTU  = 4'b1100;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, state_next;
    logic [SHW:0]       cnt, cnt_next;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0]   opnd, opnd_next;
    logic               res_load;
    logic [WIDTH-1:0]   res_y, res_hi;
    logic               res_dz;
    logic               accept;

    function automatic logic [WIDTH-1:0] alu_result(
        input logic [3:0]       f,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] z
    );
        logic [SHW-1:0]          sh;
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] zs;
        sh = z[SHW-1:0];
        xs = x;
        zs = z;
        case (f)
            OP_AND:  return x & z;
            OP_OR:   return x | z;
            OP_ADD:  return x + z;
            OP_XOR:  return x ^ z;
            OP_XNOR: return ~(x ^ z);
            OP_SUB:  return x - z;
            OP_SLT:  return {{(WIDTH-1){1'b0}}, xs < zs};
            OP_SLL:  return x << sh;
            OP_SRL:  return x >> sh;
            OP_SRA:  return xs >>> sh;
            OP_SLTU: return {{(WIDTH-1){1'b0}}, x < z};
            default: return '0;
        endcase
    endfunction

    // acc = {partial sum, remaining multiplier}; add multiplicand on LSB, then shift right
    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [2*WIDTH-1:0] p,
        input logic [WIDTH-1:0]   mcand
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? mcand : {WIDTH{1'b0}})};
        return {sum, p[WIDTH-1:1]};
    endfunction

    // acc = {remainder, dividend/quotient}; bring in next dividend bit, subtract if it fits
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [2*WIDTH-1:0] p,
        input logic [WIDTH-1:0]   d
    );
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        shifted = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        diff    = shifted - {1'b0, d};
        if (!diff[WIDTH])
            return {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        else
            return {shifted[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    endfunction

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        acc_next   = acc;
        opnd_next  = opnd;
        res_load   = 1'b0;
        res_y      = '0;
        res_hi     = '0;
        res_dz     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (state == DONE && out_ready && !in_valid)
                    state_next = IDLE;
                if (accept) begin
                    case (op)
                        OP_MULTU: begin
                            state_next = MUL;
                            cnt_next   = '0;
                            acc_next   = {{WIDTH{1'b0}}, b};
                            opnd_next  = a;
                        end
                        OP_DIVU: begin
                            if (b == '0) begin
                                state_next = DONE;
                                res_load   = 1'b1;
                                res_y      = '1;
                                res_hi     = a;
                                res_dz     = 1'b1;
                            end else begin
                                state_next = DIV;
                                cnt_next   = '0;
                                acc_next   = {{WIDTH{1'b0}}, a};
                                opnd_next  = b;
                            end
                        end
                        default: begin
                            state_next = DONE;
                            res_load   = 1'b1;
                            res_y      = alu_result(op, a, b);
                        end
                    endcase
                end
            end
            MUL: begin
                acc_next = mul_step(acc, opnd);
                cnt_next = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                    cnt_next   = '0;
                    res_load   = 1'b1;
                    res_y      = acc_next[WIDTH-1:0];
                    res_hi     = acc_next[2*WIDTH-1:WIDTH];
                end
            end
            DIV: begin
                acc_next = div_step(acc, opnd);
                cnt_next = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                    cnt_next   = '0;
                    res_load   = 1'b1;
                    res_y      = acc_next[WIDTH-1:0];
                    res_hi     = acc_next[2*WIDTH-1:WIDTH];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            acc  <= '0;
            opnd <= '0;
            y    <= '0;
            hi   <= '0;
            zero <= 1'b0;
            dz   <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            acc  <= acc_next;
            opnd <= opnd_next;
            if (res_load) begin
                y    <= res_y;
                hi   <= res_hi;
                zero <= (res_y == '0);
                dz   <= res_dz;
            end
        end
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the datapath ALU. It executes the same logic/arithmetic/compare/shift operations with a registered one-cycle result, and adds right shifts, unsigned compare, and iterative unsigned multiply and divide with a HI result. It sits in the execute stage of the pipelined MIPS core. The stall logic drives it through valid/ready, so multi-cycle mult/div stalls the pipe without extra control.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of two
- SHW, $clog2(WIDTH), derived; shift-amount bits taken from b[SHW-1:0]
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; one clock domain only
- in_valid  input  1  request present
- in_ready  output  1  request accepted on an edge where in_valid & in_ready
- op  input  4  operation code (see Operation)
- a, b  input  WIDTH  operands, sampled only at accept
- out_valid  output  1  result registers valid
- out_ready  input  1  consumer takes result on an edge where out_valid & out_ready
- y  output  WIDTH  main result / LO / quotient
- hi  output  WIDTH  HI of product / remainder; 0 for single-cycle ops
- zero  output  1  registered (y == 0), updated with y
- dz  output  1  divide-by-zero flag for the current result

## Operation
- op codes (single-cycle):
  - 0000 and; 0001 or; 0010 add (mod 2^WIDTH); 0011 xor; 0100 xnor; 0101 sub a−b (mod 2^WIDTH)
  - 0110 slt, signed, y = {0…,1} or 0; 0111 sll a<<b[SHW-1:0]; 1000 srl; 1001 sra (sign-filled)
  - 1100 sltu, unsigned
- op codes (multi-cycle): 1010 multu {hi,y} = a*b unsigned, full 2·WIDTH product; 1011 divu y = a/b, hi = a%b unsigned
- Reserved op codes (1101–1111): single-cycle, y=0, hi=0, zero=1, dz=0
- FSM states:
  - IDLE: in_ready=1. Accept of a single-cycle op goes to DONE. Accept of multu goes to MUL. Accept of divu with b≠0 goes to DIV. Accept of divu with b=0 goes to DONE.
  - MUL: shift-add, one partial product per cycle, WIDTH iterations counted by cnt (width SHW+1), then DONE
  - DIV: restoring shift-subtract, one quotient bit per cycle, WIDTH iterations, then DONE
  - DONE: out_valid=1. out_ready & ~in_valid goes to IDLE. out_ready & in_valid accepts the next request directly, with the same transitions as IDLE. ~out_ready holds all outputs stable.
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready is 0 in MUL and DIV.
- Operands and op are latched at accept. Input changes after accept have no effect.
- Divide by zero returns y = all ones, hi = a, dz=1. dz=0 for every other result.
- Result registers (y, hi, zero, dz) load only on the transition into DONE.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, y=0, hi=0, zero=0, dz=0, cnt=0. Internal product and remainder registers are also cleared.
- Latency, measured from the accepting edge to the edge after which out_valid=1:
  - single-cycle ops and divu-by-zero: 1 edge
  - multu and divu (b≠0): WIDTH+1 edges (33 for WIDTH=32)
- Throughput with out_ready held high: 1 single-cycle op per clock; 1 mult/div per WIDTH+1 clocks.
- Backpressure: out_valid and the result stay constant while out_ready=0. Nothing is dropped or overwritten.
- Reset asserted mid-MUL/DIV aborts immediately. No result is produced and the unit is in IDLE when reset releases.
- Shift amounts ≥ WIDTH cannot occur because only b[SHW-1:0] is used. sra by 0 returns a.

## Test plan
- WIDTH=32, add a=7 b=5 → y=12, zero=0, hi=0, 1-edge latency. Then sub a=4 b=4 → y=0, zero=1.
- slt a=0xFFFFFFFF b=1 → y=1; sltu with the same operands → y=0. sra a=0x80000000 b=4 → y=0xF8000000. srl with the same operands → y=0x08000000.
- multu a=0xFFFFFFFF b=2 → hi=1, y=0xFFFFFFFE. out_valid rises exactly 33 edges after accept, and in_ready=0 throughout.
- divu a=10 b=3 → y=3, hi=1, dz=0 after 33 edges. divu a=9 b=0 → y=0xFFFFFFFF, hi=9, dz=1 after 1 edge.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles after an add result: y is held and in_ready=0.
  - Raise out_ready with in_valid=1 (xor a=0xF0 b=0xFF): the xor is accepted on the same edge and y=0x0F on the next edge.
- Assert reset 10 cycles into a multu: out_valid=0 and all outputs return to their reset values while reset is high. After release, a WIDTH=8 instance computing multu 0xFF*0xFF gives hi=0xFE, y=0x01 in 9 edges.
